// File: rtl/mem_port_arbiter.sv
// Single memory port shared by icache (read-only) and dcache (read/write).
// One line transaction at a time, split into BEATS beats of BEAT_W bits.
module mem_port_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  owner_e            grant;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0] i_line_q, i_line_d;
  logic [LINE_W-1:0] d_line_q, d_line_d;
  logic              d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      last_q   <= OWN_I;
      cnt_q    <= '0;
      addr_q   <= '0;
      wbuf_q   <= '0;
      buf_q    <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wbuf_q   <= wbuf_d;
      buf_q    <= buf_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wbuf_d   = wbuf_q;
    buf_d    = buf_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;
    grant    = OWN_I;

    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    i_rdata     = i_line_q;
    d_rdata     = d_line_q;

    unique case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          // Tie goes to whoever was not granted last; d_read+d_write counts as a write.
          grant   = (d_req && (!i_read || last_q == OWN_I)) ? OWN_D : OWN_I;
          owner_d = grant;
          last_d  = grant;
          cnt_d   = '0;
          wbuf_d  = d_wdata;
          addr_d  = ((grant == OWN_D) ? d_address : i_address) & ~OFF_MASK;
          state_d = (grant == OWN_D && d_write) ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        if (mem_resp) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) buf_d[b*BEAT_W +: BEAT_W] = mem_rdata;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      WR_BURST: begin
        mem_write   = 1'b1;
        mem_address = addr_q;
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (cnt_q == CNT_W'(b)) mem_wdata = wbuf_q[b*BEAT_W +: BEAT_W];
        end
        if (mem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // Owner sees buf directly this cycle; the hold register takes it for later cycles.
        if (owner_q == OWN_I) begin
          i_resp   = 1'b1;
          i_rdata  = buf_q;
          i_line_d = buf_q;
        end else begin
          d_resp   = 1'b1;
          d_rdata  = buf_q;
          d_line_d = buf_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
